axi4_lite_master_read_pipe: RTL and testbench

Parametrised AXI4-Lite read master that converts a local valid/ready request stream into AR transactions and returns R beats through a buffered local response stream. It supports up to MAX_OUTSTANDING reads in flight and a response FIFO that decouples the R channel from the local consumer. It sits between local logic and the AXI4-Lite interconnect, alongside the write-side master.

---
 rtl/axi4_lite_master_read_pipe.sv | 170 +++++++++++++++++
 tb/tb_axi4_lite_master_read_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master_read_pipe.sv
// axi4_lite_master_read_pipe
//   AXI4-Lite read master. Local valid/ready requests become AR transactions;
//   R beats go into a small response FIFO that feeds the local consumer.
//   Up to MAX_OUTSTANDING reads may be accepted but not yet answered.
//
// Optional feature macro: AXI4_LITE_RD_TIMEOUT_EN. When it is defined, a
//   watchdog sets the sticky TIMEOUT flag if reads stay outstanding for
//   TIMEOUT_CYCLES cycles with no R handshake. When it is undefined, TIMEOUT
//   is tied to 0.
//
// Ports:
//   ACLK, ARESETn                  clock, synchronous active-low reset
//   ARVALID/ARREADY/ARADDR/ARPROT  AXI read address channel (ARPROT = 0)
//   RVALID/RREADY/RDATA/RRESP      AXI read data channel
//   USR_REQ_VALID/READY, USR_ADDR  local request stream
//   USR_RSP_VALID/READY            local response stream (head of the FIFO)
//   USR_RDATA, USR_RRESP           response data and code
//   OUTSTANDING                    reads in flight
//   TIMEOUT                        sticky watchdog flag
module axi4_lite_master_read_pipe #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned RSP_DEPTH       = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [2:0]        ARPROT,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              USR_REQ_VALID,
  output logic              USR_REQ_READY,
  input  logic [ADDR_W-1:0] USR_ADDR,
  output logic              USR_RSP_VALID,
  input  logic              USR_RSP_READY,
  output logic [DATA_W-1:0] USR_RDATA,
  output logic [1:0]        USR_RRESP,
  output logic [3:0]        OUTSTANDING,
  output logic              TIMEOUT
);

  localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StAddr} ar_state_e;

  ar_state_e           ar_state_q;
  logic [ADDR_W-1:0]   araddr_q;
  logic [3:0]          outstanding_q, outstanding_d;
  logic                rready_q, rready_d;
  logic [DATA_W+1:0]   mem_q [RSP_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;

  logic req_accept, r_hs, push, pop;

  // Ready depends only on registers, never on USR_REQ_VALID.
  assign USR_REQ_READY = (ar_state_q == StIdle) && (outstanding_q < 4'(MAX_OUTSTANDING));
  assign req_accept    = USR_REQ_VALID && USR_REQ_READY;
  assign r_hs          = RVALID && rready_q;
  assign push          = r_hs;
  assign pop           = USR_RSP_VALID && USR_RSP_READY;

  assign ARVALID       = (ar_state_q == StAddr);
  assign ARADDR        = araddr_q;
  assign ARPROT        = 3'b000;
  assign RREADY        = rready_q;
  assign OUTSTANDING   = outstanding_q;
  assign USR_RSP_VALID = (count_q != '0);
  assign {USR_RDATA, USR_RRESP} = mem_q[rd_ptr_q];

  // AR channel: address held stable until the slave takes it.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      ar_state_q <= StIdle;
      araddr_q   <= '0;
    end else begin
      unique case (ar_state_q)
        StIdle: begin
          if (req_accept) begin
            ar_state_q <= StAddr;
            araddr_q   <= USR_ADDR;
          end
        end
        StAddr: begin
          if (ARREADY) ar_state_q <= StIdle;
        end
        default: ar_state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({req_accept, r_hs})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PtrW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PtrW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    // Space is judged without counting a possible pop next cycle, so RREADY
    // never depends on USR_RSP_READY combinationally.
    rready_d = (count_d < CntW'(RSP_DEPTH)) && (outstanding_d != 4'd0);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      outstanding_q <= '0;
      rready_q      <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      rready_q      <= rready_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge ACLK) begin
    if (push) mem_q[wr_ptr_q] <= {RDATA, RRESP};
  end

`ifdef AXI4_LITE_RD_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmrW-1:0] tmr_q;
  logic            timeout_q;

  // Counter saturates at the limit so it cannot wrap back below it.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      tmr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (r_hs || (outstanding_q == 4'd0)) begin
        tmr_q <= '0;
      end else if (tmr_q != TmrW'(TIMEOUT_CYCLES)) begin
        tmr_q <= tmr_q + 1'b1;
      end
      if (tmr_q == TmrW'(TIMEOUT_CYCLES)) timeout_q <= 1'b1;
    end
  end

  assign TIMEOUT = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_lite_master_read_pipe.sv
module tb_axi4_lite_master_read_pipe;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        RVALID, RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        USR_REQ_VALID, USR_REQ_READY;
  logic [31:0] USR_ADDR;
  logic        USR_RSP_VALID, USR_RSP_READY;
  logic [31:0] USR_RDATA;
  logic [1:0]  USR_RRESP;
  logic [3:0]  OUTSTANDING;
  logic        TIMEOUT;

  int n_tests = 0;
  int n_fail  = 0;

  axi4_lite_master_read_pipe #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .MAX_OUTSTANDING(4),
    .RSP_DEPTH      (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .ACLK         (ACLK),
    .ARESETn      (ARESETn),
    .ARVALID      (ARVALID),
    .ARREADY      (ARREADY),
    .ARADDR       (ARADDR),
    .ARPROT       (ARPROT),
    .RVALID       (RVALID),
    .RREADY       (RREADY),
    .RDATA        (RDATA),
    .RRESP        (RRESP),
    .USR_REQ_VALID(USR_REQ_VALID),
    .USR_REQ_READY(USR_REQ_READY),
    .USR_ADDR     (USR_ADDR),
    .USR_RSP_VALID(USR_RSP_VALID),
    .USR_RSP_READY(USR_RSP_READY),
    .USR_RDATA    (USR_RDATA),
    .USR_RRESP    (USR_RRESP),
    .OUTSTANDING  (OUTSTANDING),
    .TIMEOUT      (TIMEOUT)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  // One read with ARREADY already high: accept edge, then AR handshake edge.
  task automatic issue(input logic [31:0] addr);
    int waited;
    USR_REQ_VALID = 1'b1;
    USR_ADDR      = addr;
    waited        = 0;
    while (!USR_REQ_READY && waited < 50) begin
      step();
      waited++;
    end
    if (!USR_REQ_READY) check("issue_ready_bound", 64'(USR_REQ_READY), 64'd1);
    step();
    USR_REQ_VALID = 1'b0;
    step();
  endtask

  task automatic pop_check(input string tag, input logic [31:0] data, input logic [1:0] resp);
    check({tag, "_valid"}, 64'(USR_RSP_VALID), 64'd1);
    check({tag, "_data"}, 64'(USR_RDATA), 64'(data));
    check({tag, "_resp"}, 64'(USR_RRESP), 64'(resp));
    USR_RSP_READY = 1'b1;
    step();
    USR_RSP_READY = 1'b0;
  endtask

  initial begin
    ARESETn = 1'b0; ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = '0;
    USR_REQ_VALID = 1'b0; USR_ADDR = '0; USR_RSP_READY = 1'b0;
    step(2);
    ARESETn = 1'b1;

    // Reset state
    check("rst_arvalid", 64'(ARVALID), 64'd0);
    check("rst_araddr", 64'(ARADDR), 64'd0);
    check("rst_rready", 64'(RREADY), 64'd0);
    check("rst_rsp_valid", 64'(USR_RSP_VALID), 64'd0);
    check("rst_outstanding", 64'(OUTSTANDING), 64'd0);
    check("rst_timeout", 64'(TIMEOUT), 64'd0);
    check("rst_req_ready", 64'(USR_REQ_READY), 64'd1);
    check("arprot", 64'(ARPROT), 64'd0);

    // Single read
    ARREADY = 1'b1;
    USR_REQ_VALID = 1'b1;
    USR_ADDR = 32'h1000_0040;
    step();
    USR_REQ_VALID = 1'b0;
    check("t1_arvalid", 64'(ARVALID), 64'd1);
    check("t1_araddr", 64'(ARADDR), 64'h1000_0040);
    check("t1_out1", 64'(OUTSTANDING), 64'd1);
    check("t1_rready", 64'(RREADY), 64'd1);
    step();
    check("t1_arvalid_drop", 64'(ARVALID), 64'd0);
    step();
    RVALID = 1'b1; RDATA = 32'hDEAD_BEEF; RRESP = 2'b00;
    step();
    RVALID = 1'b0;
    check("t1_out0", 64'(OUTSTANDING), 64'd0);
    check("t1_rready_off", 64'(RREADY), 64'd0);
    pop_check("t1_rsp", 32'hDEAD_BEEF, 2'b00);
    check("t1_empty", 64'(USR_RSP_VALID), 64'd0);

    // AR stall: ARREADY low for 5 cycles
    ARREADY = 1'b0;
    USR_REQ_VALID = 1'b1;
    USR_ADDR = 32'hA5A5_0008;
    step();
    USR_REQ_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_arvalid", 64'(ARVALID), 64'd1);
      check("t2_araddr", 64'(ARADDR), 64'hA5A5_0008);
      check("t2_req_ready", 64'(USR_REQ_READY), 64'd0);
      step();
    end
    ARREADY = 1'b1;
    step();
    check("t2_arvalid_drop", 64'(ARVALID), 64'd0);
    check("t2_out", 64'(OUTSTANDING), 64'd1);
    RVALID = 1'b1; RDATA = 32'h1111_2222; RRESP = 2'b00;
    step();
    RVALID = 1'b0;
    pop_check("t2_rsp", 32'h1111_2222, 2'b00);

    // Outstanding limit
    for (int i = 0; i < 4; i++) issue(32'h2000_0000 + 32'(i * 4));
    check("t3_out4", 64'(OUTSTANDING), 64'd4);
    check("t3_req_ready0", 64'(USR_REQ_READY), 64'd0);
    USR_REQ_VALID = 1'b1;
    USR_ADDR = 32'h2000_0010;
    step(2);
    check("t3_stalled_arvalid", 64'(ARVALID), 64'd0);
    check("t3_stalled_out", 64'(OUTSTANDING), 64'd4);
    RVALID = 1'b1; RDATA = 32'hC000_0000; RRESP = 2'b00;
    step();
    RVALID = 1'b0;
    check("t3_out3", 64'(OUTSTANDING), 64'd3);
    check("t3_req_ready1", 64'(USR_REQ_READY), 64'd1);
    step();
    USR_REQ_VALID = 1'b0;
    check("t3_5th_arvalid", 64'(ARVALID), 64'd1);
    check("t3_5th_araddr", 64'(ARADDR), 64'h2000_0010);
    check("t3_5th_out", 64'(OUTSTANDING), 64'd4);
    step();
    // Drain with consumer always ready: one beat per cycle
    USR_RSP_READY = 1'b1;
    check("t3_head0", 64'(USR_RDATA), 64'hC000_0000);
    for (int i = 1; i <= 4; i++) begin
      check("t3_rready_stream", 64'(RREADY), 64'd1);
      RVALID = 1'b1; RDATA = 32'hC000_0000 + 32'(i); RRESP = 2'b00;
      step();
      check("t3_stream_data", 64'(USR_RDATA), 64'hC000_0000 + 64'(i));
    end
    RVALID = 1'b0;
    step();
    USR_RSP_READY = 1'b0;
    check("t3_drained", 64'(USR_RSP_VALID), 64'd0);
    check("t3_out0", 64'(OUTSTANDING), 64'd0);

    // FIFO full backpressure
    for (int i = 0; i < 3; i++) issue(32'h3000_0000 + 32'(i * 4));
    check("t4_rready", 64'(RREADY), 64'd1);
    RVALID = 1'b1; RDATA = 32'hE000_0000; RRESP = 2'b00;
    step();
    check("t4_rready_1push", 64'(RREADY), 64'd1);
    RDATA = 32'hE000_0001;
    step();
    check("t4_rready_full", 64'(RREADY), 64'd0);
    RDATA = 32'hE000_0002;
    step(2);
    check("t4_out_held", 64'(OUTSTANDING), 64'd1);
    check("t4_rready_still0", 64'(RREADY), 64'd0);
    pop_check("t4_rsp0", 32'hE000_0000, 2'b00);
    check("t4_rready_back", 64'(RREADY), 64'd1);
    step();
    RVALID = 1'b0;
    check("t4_out0", 64'(OUTSTANDING), 64'd0);
    pop_check("t4_rsp1", 32'hE000_0001, 2'b00);
    pop_check("t4_rsp2", 32'hE000_0002, 2'b00);

    // SLVERR on the second read only
    issue(32'h4000_0000);
    issue(32'h4000_0004);
    RVALID = 1'b1; RDATA = 32'hF000_0000; RRESP = 2'b00;
    step();
    RDATA = 32'hF000_0001; RRESP = 2'b10;
    step();
    RVALID = 1'b0; RRESP = 2'b00;
    pop_check("t5_rsp0", 32'hF000_0000, 2'b00);
    pop_check("t5_rsp1", 32'hF000_0001, 2'b10);
    issue(32'h4000_0008);
    RVALID = 1'b1; RDATA = 32'hF000_0002; RRESP = 2'b00;
    step();
    RVALID = 1'b0;
    pop_check("t5_rsp2", 32'hF000_0002, 2'b00);

    // Watchdog: read left unanswered
    issue(32'h5000_0000);
    step(8);
    check("t6_timeout_early", 64'(TIMEOUT), 64'd0);
    step(20);
`ifdef AXI4_LITE_RD_TIMEOUT_EN
    check("t6_timeout_set", 64'(TIMEOUT), 64'd1);
    step(10);
    check("t6_timeout_sticky", 64'(TIMEOUT), 64'd1);
`else
    check("t6_timeout_tied", 64'(TIMEOUT), 64'd0);
`endif
    check("t6_out_pending", 64'(OUTSTANDING), 64'd1);
    ARESETn = 1'b0;
    step();
    ARESETn = 1'b1;
    check("t6_rst_timeout", 64'(TIMEOUT), 64'd0);
    check("t6_rst_out", 64'(OUTSTANDING), 64'd0);
    check("t6_rst_rready", 64'(RREADY), 64'd0);
    check("t6_rst_rsp_valid", 64'(USR_RSP_VALID), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
